// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins by default; fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  output logic            o_if_done,
  output logic [DW-1:0]   o_if_rdata,
  input  logic            i_dm_req,
  input  logic            i_dm_we,
  input  logic [DW/8-1:0] i_dm_be,
  input  logic [AW-1:0]   i_dm_addr,
  input  logic [DW-1:0]   i_dm_wdata,
  output logic            o_dm_done,
  output logic [DW-1:0]   o_dm_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [DW/8-1:0] o_mem_be,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic            i_mem_ready,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_stall_if,
  output logic            o_stall_mem,
  output logic            o_bus_err
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [SW-1:0]   r_starve_cnt, w_starve_cnt;
  logic [TW-1:0]   r_tmo_cnt, w_tmo_cnt;
  logic            r_owner_d, w_owner_d;
  logic            r_mem_req, w_mem_req;
  logic            r_mem_we, w_mem_we;
  logic [BW-1:0]   r_mem_be, w_mem_be;
  logic [AW-1:0]   r_mem_addr, w_mem_addr;
  logic [DW-1:0]   r_mem_wdata, w_mem_wdata;
  logic            r_if_done, w_if_done;
  logic            r_dm_done, w_dm_done;
  logic [DW-1:0]   r_if_rdata, w_if_rdata;
  logic [DW-1:0]   r_dm_rdata, w_dm_rdata;
  logic            r_bus_err, w_bus_err;
  logic            w_grant_d, w_grant_i, w_fin;
  logic [DW-1:0]   w_rd;

  // Next-state, arbitration and response capture
  always_comb begin
    w_state      = r_state;
    w_starve_cnt = r_starve_cnt;
    w_tmo_cnt    = r_tmo_cnt;
    w_owner_d    = r_owner_d;
    w_mem_req    = r_mem_req;
    w_mem_we     = r_mem_we;
    w_mem_be     = r_mem_be;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_if_done    = 1'b0;
    w_dm_done    = 1'b0;
    w_if_rdata   = {DW{1'b0}};
    w_dm_rdata   = {DW{1'b0}};
    w_bus_err    = 1'b0;
    w_fin        = 1'b0;
    w_rd         = {DW{1'b0}};
    w_grant_d    = i_dm_req && !(i_if_req && (r_starve_cnt == SW'(STARVE_LIMIT)));
    w_grant_i    = !w_grant_d && i_if_req;

    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state     = S_ACCESS;
          w_owner_d   = 1'b1;
          w_mem_req   = 1'b1;
          w_mem_we    = i_dm_we;
          w_mem_be    = i_dm_be;
          w_mem_addr  = i_dm_addr;
          w_mem_wdata = i_dm_wdata;
          if (i_if_req && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
            w_starve_cnt = r_starve_cnt + SW'(1);
          end else begin
            w_starve_cnt = r_starve_cnt;
          end
        end else if (w_grant_i) begin
          w_state      = S_ACCESS;
          w_owner_d    = 1'b0;
          w_mem_req    = 1'b1;
          w_mem_we     = 1'b0;
          w_mem_be     = {BW{1'b1}};
          w_mem_addr   = i_if_addr;
          w_mem_wdata  = {DW{1'b0}};
          w_starve_cnt = {SW{1'b0}};
        end else begin
          w_state = S_IDLE;
        end
      end

      S_ACCESS: begin
        w_tmo_cnt = r_tmo_cnt + TW'(1);
        // A ready in the final timeout cycle still counts as a good completion
        if (i_mem_ready) begin
          w_fin = 1'b1;
          w_rd  = r_mem_we ? {DW{1'b0}} : i_mem_rdata;
        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_fin     = 1'b1;
          w_bus_err = 1'b1;
        end else begin
          w_fin = 1'b0;
        end
        if (w_fin) begin
          w_state    = S_RESP;
          w_tmo_cnt  = {TW{1'b0}};
          w_mem_req  = 1'b0;
          w_if_done  = !r_owner_d;
          w_dm_done  = r_owner_d;
          w_if_rdata = r_owner_d ? {DW{1'b0}} : w_rd;
          w_dm_rdata = r_owner_d ? w_rd : {DW{1'b0}};
        end else begin
          w_state = S_ACCESS;
        end
      end

      S_RESP: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state   = S_IDLE;
        w_mem_req = 1'b0;
        w_tmo_cnt = {TW{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= {SW{1'b0}};
      r_tmo_cnt    <= {TW{1'b0}};
      r_owner_d    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= {BW{1'b0}};
      r_mem_addr   <= {AW{1'b0}};
      r_mem_wdata  <= {DW{1'b0}};
      r_if_done    <= 1'b0;
      r_dm_done    <= 1'b0;
      r_if_rdata   <= {DW{1'b0}};
      r_dm_rdata   <= {DW{1'b0}};
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_starve_cnt <= w_starve_cnt;
      r_tmo_cnt    <= w_tmo_cnt;
      r_owner_d    <= w_owner_d;
      r_mem_req    <= w_mem_req;
      r_mem_we     <= w_mem_we;
      r_mem_be     <= w_mem_be;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_if_done    <= w_if_done;
      r_dm_done    <= w_dm_done;
      r_if_rdata   <= w_if_rdata;
      r_dm_rdata   <= w_dm_rdata;
      r_bus_err    <= w_bus_err;
    end
  end

  assign o_if_done   = r_if_done;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_done   = r_dm_done;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_bus_err   = r_bus_err;
  assign o_stall_if  = i_if_req & ~r_if_done;
  assign o_stall_mem = i_dm_req & ~r_dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small configurable memory responder.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        if_done, dm_done, mem_req, mem_we, stall_if, stall_mem, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        resp_en, tie_ready;
  int          resp_wait, rcnt;
  logic [31:0] resp_data;
  int          n_checks, n_errors;
  int          cyc, hi;
  logic [9:0]  exp_seq;

  mem_port_arbiter dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_be(dm_be), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .o_dm_done(dm_done), .o_dm_rdata(dm_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_stall_if(stall_if), .o_stall_mem(stall_mem), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = resp_data;

  // Memory responder: raises ready resp_wait cycles into an access
  always @(negedge clk) begin
    if (tie_ready) begin
      mem_ready = 1'b1;
    end else if (!mem_req) begin
      mem_ready = 1'b0;
      rcnt = 0;
    end else if (!resp_en) begin
      mem_ready = 1'b0;
    end else if (rcnt == resp_wait) begin
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'b0;
      rcnt = rcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      n = n + 1;
      if (if_done || dm_done) return;
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    resp_en = 1'b1; tie_ready = 1'b0; resp_wait = 0; rcnt = 0; resp_data = 32'h0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 64'd0);
    check("rst_if_done", if_done, 64'd0);
    check("rst_dm_done", dm_done, 64'd0);
    check("rst_bus_err", bus_err, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    reset = 1'b1;

    // Fetch only, ready two cycles after mem_req
    @(negedge clk);
    resp_wait = 2; resp_data = 32'h0000_0013;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0004;
    @(negedge clk);
    check("f_mem_req", mem_req, 64'd1);
    check("f_mem_addr", mem_addr, 64'h4);
    check("f_mem_we", mem_we, 64'd0);
    check("f_mem_be", mem_be, 64'hF);
    check("f_stall_if", stall_if, 64'd1);
    wait_done(30, cyc);
    check("f_latency", cyc, 64'd3);
    check("f_if_done", if_done, 64'd1);
    check("f_if_rdata", if_rdata, 64'h13);
    check("f_stall_if_done", stall_if, 64'd0);
    check("f_dm_done", dm_done, 64'd0);
    if_req = 1'b0;

    // Simultaneous requests: data store first
    resp_wait = 0; resp_data = 32'h55;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    check("s_mem_we", mem_we, 64'd1);
    check("s_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    check("s_mem_addr", mem_addr, 64'h100);
    check("s_stall_if", stall_if, 64'd1);
    @(negedge clk);
    check("s_dm_done", dm_done, 64'd1);
    check("s_dm_rdata", dm_rdata, 64'd0);
    check("s_if_done_off", if_done, 64'd0);
    check("s_if_rdata_off", if_rdata, 64'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    wait_done(20, cyc);
    check("s_fetch_lat", cyc, 64'd3);
    check("s_if_done", if_done, 64'd1);
    check("s_if_rdata", if_rdata, 64'h55);
    if_req = 1'b0;

    // Starvation: both requests held, zero-wait memory
    @(negedge clk);
    resp_data = 32'h77; exp_seq = 10'b10_0001_0000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'hC;
    for (int i = 0; i < 10; i++) begin
      wait_done(10, cyc);
      check("starve_owner", if_done, exp_seq[i]);
    end
    dm_req = 1'b0; if_req = 1'b0;

    // Timeout: ready never comes
    resp_en = 1'b0;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req) hi = hi + 1;
      if (dm_done) break;
    end
    check("t_access_len", hi, 64'd15);
    check("t_dm_done", dm_done, 64'd1);
    check("t_bus_err", bus_err, 64'd1);
    check("t_dm_rdata", dm_rdata, 64'd0);
    check("t_mem_req", mem_req, 64'd0);
    dm_req = 1'b0;
    @(negedge clk);
    check("t_bus_err_pulse", bus_err, 64'd0);

    // Ready in the last timeout cycle wins
    resp_en = 1'b1; resp_wait = 14; resp_data = 32'hA5A5;
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h210;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req) hi = hi + 1;
      if (dm_done) break;
    end
    check("r_access_len", hi, 64'd15);
    check("r_dm_done", dm_done, 64'd1);
    check("r_bus_err", bus_err, 64'd0);
    check("r_dm_rdata", dm_rdata, 64'hA5A5);
    dm_req = 1'b0;

    // Reset in the middle of an access
    resp_en = 1'b0;
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h300;
    @(negedge clk);
    check("x_mem_req", mem_req, 64'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("x_async_clr", mem_req, 64'd0);
    @(negedge clk);
    check("x_no_done1", dm_done, 64'd0);
    @(negedge clk);
    check("x_no_done2", dm_done, 64'd0);
    reset = 1'b1; resp_en = 1'b1; resp_wait = 0; resp_data = 32'h3C;
    @(negedge clk);
    check("x_regrant", mem_req, 64'd1);
    check("x_regrant_addr", mem_addr, 64'h300);
    wait_done(10, cyc);
    check("x_dm_done", dm_done, 64'd1);
    check("x_dm_rdata", dm_rdata, 64'h3C);
    dm_req = 1'b0;

    // Ready tied high: one completion every 3 cycles
    @(negedge clk);
    tie_ready = 1'b1; resp_data = 32'h99;
    dm_req = 1'b1; dm_addr = 32'h400;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("stream_done", dm_done, (i % 3) == 2);
      if (i == 2) begin
        check("stream_rdata", dm_rdata, 64'h99);
        check("stream_stall", stall_mem, 64'd0);
      end
    end
    dm_req = 1'b0; tie_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
